motion_detector: RTL and testbench
==================================

# motion_detector

Frame-difference motion detector sitting directly upstream of the quadrant RGB output mux. It consumes a streamed pair of 4-bit grayscale pixels (current frame, previous frame from the frame buffer) and produces a per-pixel binary difference image for the bottom-right quadrant. At every frame boundary it counts changed pixels and asserts `motion_detected`, held for a programmable number of frames, which drives the red motion marker in the top-left quadrant.

## Interface
- `PIX_THRESH`, 3: minimum absolute difference (0–15) for a pixel to count as changed.
- `COUNT_THRESH`, 200: minimum changed pixels per frame to declare motion.
- `HOLD_FRAMES`, 30: number of frames `motion_detected` stays high after the last qualifying frame; range 1–255.
- `CNT_W`, 17: width of the pixel accumulator; covers 320×240.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_end`  in  1  one-cycle pulse closing the current frame.
- `pix_valid`  in  1  `cur_gray`/`prev_gray` valid this cycle.
- `cur_gray`  in  4  current-frame grayscale pixel.
- `prev_gray`  in  4  co-located previous-frame pixel.
- `diff_valid`  out  1  `diff_pixel` valid.
- `diff_pixel`  out  4  4'hF if changed, 4'h0 otherwise.
- `motion_detected`  out  1  registered motion flag.
- `motion_count`  out  CNT_W  changed-pixel count of the last closed frame.

## Operation
- Stage 1 registers `|cur_gray − prev_gray|`, computed 5-bit signed and then truncated to 4 bits, together with `pix_valid`.
- Stage 2 registers `hit = (absdiff >= PIX_THRESH)`. It drives `diff_pixel = hit ? 4'hF : 4'h0` and `diff_valid`.
- Accumulator `acc` increments on each valid stage-2 hit. It saturates at 2^CNT_W−1 and never wraps.
- `frame_end` is delayed 2 cycles (`fe_d2`) so it aligns with stage 2. A pixel presented in the same cycle as `frame_end` belongs to the closing frame.
- Frame close (`fe_d2`): `total = sat(acc + hit_valid)`, `motion_count <= total`, `acc <= 0`.
- FSM `WARMUP` → `RUN`:
  - `WARMUP` is the reset state, because the previous-frame buffer is invalid. At the first frame close, update `motion_count` but do not evaluate motion, then go to `RUN`.
  - `RUN`: at each close, if `total >= COUNT_THRESH` then `hold_cnt <= HOLD_FRAMES`; else if `hold_cnt != 0` then `hold_cnt <= hold_cnt − 1`.
- `motion_detected` is registered as `hold_cnt != 0` of the updated value.
- `frame_end` asserted with no pixels in the frame: `total = 0`, normal evaluation.
- Back-to-back `frame_end` pulses: each one is a separate close.

## Timing
- Reset values (all outputs 0):
  - `diff_valid`, `diff_pixel`, `motion_detected`, `motion_count`;
  - internal `acc`, `hold_cnt`, pipeline registers;
  - state = `WARMUP`.
- Pixel sampled at the edge ending cycle N: `diff_valid`/`diff_pixel` visible in cycle N+2. Throughput is 1 pixel per cycle, with no backpressure.
- `frame_end` in cycle F: `motion_count` and `motion_detected` update at the edge ending F+2, visible from F+3.
- A pixel in cycle F+1 (after `frame_end`) counts toward the next frame.
- Motion falls when `hold_cnt` reaches 0:
  - after the last qualifying close, `motion_detected` stays high through exactly `HOLD_FRAMES`−1 further non-qualifying closes;
  - it falls at the `HOLD_FRAMES`-th non-qualifying close.
- Asynchronous `reset` mid-frame discards `acc` and returns to `WARMUP`. The next frame close is again not evaluated.

## Structure
- Shared package `motion_pkg` holds:
  - `GRAY_W = 4`;
  - the FSM state enum `motion_state_t {WARMUP, RUN}`;
  - default thresholds.
- One natural sub-module: `abs_diff_thresh`, the 2-stage per-pixel pipeline producing `hit`/`hit_valid`. The top level holds the accumulator, frame-close logic, FSM and hold counter.

## Test plan
- Reset, then pixel cur=9, prev=5 at cycle N → `diff_valid`=1 and `diff_pixel`=4'hF at N+2. cur=5, prev=7 → `diff_pixel`=4'h0, since 2<3.
- First frame of 250 hits then `frame_end` → `motion_count`=250, `motion_detected`=0 (WARMUP). Second identical frame → `motion_detected`=1 at F+3.
- `HOLD_FRAMES`=3: one qualifying frame, then 0-hit frames → `motion_detected` high after closes 1–3 (qualifying + 2 quiet), low after the 3rd quiet close.
- `COUNT_THRESH` boundary in `RUN`: 199 hits → no motion; 200 hits with the last hit coincident with `frame_end` → motion; a hit at F+1 → counted in the next frame's `motion_count`.
- `CNT_W`=4: 20 hits in one frame → `motion_count`=15 (saturated).
- `reset` asserted mid-frame in `RUN` with `motion_detected`=1 → all outputs 0 immediately. The next 300-hit frame close gives `motion_count`=300, `motion_detected`=0 (back in WARMUP).

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and default tuning for the frame-difference motion detector.
package motion_pkg;

  localparam int unsigned GRAY_W = 4;

  // Default tuning values; a 17-bit accumulator covers a 320x240 frame.
  localparam int unsigned DefPixThresh   = 3;
  localparam int unsigned DefCountThresh = 200;
  localparam int unsigned DefHoldFrames  = 30;
  localparam int unsigned DefCntW        = 17;

  // WARMUP: the previous-frame buffer is not yet meaningful, so the first close is not evaluated.
  typedef enum logic {WARMUP, RUN} motion_state_t;

endpackage

// File: rtl/abs_diff_thresh.sv
// Two-stage per-pixel pipeline: stage 1 registers |cur - prev|, stage 2 registers the
// threshold decision. hit/hit_valid are two cycles behind the input pixel.
module abs_diff_thresh
  import motion_pkg::*;
#(
  parameter int unsigned PIX_THRESH = DefPixThresh
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [GRAY_W-1:0] cur_gray,
  input  logic [GRAY_W-1:0] prev_gray,
  output logic              hit,
  output logic              hit_valid
);

  logic [GRAY_W:0]   diff;
  logic [GRAY_W:0]   mag;
  logic [GRAY_W-1:0] absdiff_d, absdiff_q;
  logic              v1_d, v1_q;
  logic              hit_d, hit_q;
  logic              hv_d, hv_q;

  // Next-state for both pipeline stages; the difference is taken one bit wider so the sign survives.
  always_comb begin
    diff      = {1'b0, cur_gray} - {1'b0, prev_gray};
    mag       = diff[GRAY_W] ? ((GRAY_W + 1)'(0) - diff) : diff;
    absdiff_d = mag[GRAY_W-1:0];
    v1_d      = pix_valid;
    hit_d     = (32'(absdiff_q) >= PIX_THRESH);
    hv_d      = v1_q;
  end

  // Pipeline registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      absdiff_q <= '0;
      v1_q      <= 1'b0;
      hit_q     <= 1'b0;
      hv_q      <= 1'b0;
    end else begin
      absdiff_q <= absdiff_d;
      v1_q      <= v1_d;
      hit_q     <= hit_d;
      hv_q      <= hv_d;
    end
  end

  assign hit       = hit_q;
  assign hit_valid = hv_q;

endmodule

// File: rtl/motion_detector.sv
// Frame-difference motion detector: per-pixel binary difference image, per-frame changed-pixel
// count, and a motion flag held for HOLD_FRAMES closes after the last qualifying frame.
module motion_detector
  import motion_pkg::*;
#(
  parameter int unsigned PIX_THRESH   = DefPixThresh,
  parameter int unsigned COUNT_THRESH = DefCountThresh,
  parameter int unsigned HOLD_FRAMES  = DefHoldFrames,
  parameter int unsigned CNT_W        = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [GRAY_W-1:0] cur_gray,
  input  logic [GRAY_W-1:0] prev_gray,
  output logic              diff_valid,
  output logic [GRAY_W-1:0] diff_pixel,
  output logic              motion_detected,
  output logic [CNT_W-1:0]  motion_count
);

  localparam logic [CNT_W-1:0] AccMax   = {CNT_W{1'b1}};
  localparam logic [7:0]       HoldInit = 8'(HOLD_FRAMES);

  logic             hit, hit_valid, hit_inc;
  logic [CNT_W-1:0] total;
  logic             fe_d1_d, fe_d1_q;
  logic             fe_d2_d, fe_d2_q;
  logic [CNT_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [7:0]       hold_d, hold_q;
  logic             md_d, md_q;
  motion_state_t    state_d, state_q;

  abs_diff_thresh #(
    .PIX_THRESH (PIX_THRESH)
  ) u_abs_diff_thresh (
    .clk       (clk),
    .reset     (reset),
    .pix_valid (pix_valid),
    .cur_gray  (cur_gray),
    .prev_gray (prev_gray),
    .hit       (hit),
    .hit_valid (hit_valid)
  );

  assign hit_inc    = hit & hit_valid;
  assign diff_valid = hit_valid;
  assign diff_pixel = hit ? 4'hF : 4'h0;

  // Accumulate, close frames on the delayed frame_end, and run the WARMUP/RUN hold logic.
  always_comb begin
    fe_d1_d = frame_end;
    fe_d2_d = fe_d1_q;
    // Saturating increment; the stage-2 hit coincident with the close still belongs to that frame.
    total   = (hit_inc && (acc_q != AccMax)) ? (acc_q + CNT_W'(1)) : acc_q;
    acc_d   = total;
    count_d = count_q;
    hold_d  = hold_q;
    state_d = state_q;
    if (fe_d2_q) begin
      acc_d   = '0;
      count_d = total;
      unique case (state_q)
        WARMUP: state_d = RUN;
        RUN: begin
          if (32'(total) >= COUNT_THRESH) begin
            hold_d = HoldInit;
          end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
          end
        end
        default: state_d = WARMUP;
      endcase
    end
    md_d = (hold_d != 8'd0);
  end

  // Frame-level state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_d1_q <= 1'b0;
      fe_d2_q <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      hold_q  <= 8'd0;
      md_q    <= 1'b0;
      state_q <= WARMUP;
    end else begin
      fe_d1_q <= fe_d1_d;
      fe_d2_q <= fe_d2_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      hold_q  <= hold_d;
      md_q    <= md_d;
      state_q <= state_d;
    end
  end

  assign motion_detected = md_q;
  assign motion_count    = count_q;

endmodule

// File: tb/tb_motion_detector.sv
// Directed bench: dut_a uses default parameters; dut_b (HOLD_FRAMES=3, CNT_W=4, COUNT_THRESH=10)
// shares the same stimulus and covers the short hold and accumulator saturation.
module tb_motion_detector;
  import motion_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_end;
  logic       pix_valid;
  logic [3:0] cur_gray;
  logic [3:0] prev_gray;

  logic        a_diff_valid, b_diff_valid;
  logic [3:0]  a_diff_pixel, b_diff_pixel;
  logic        a_md, b_md;
  logic [16:0] a_count;
  logic [3:0]  b_count;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] cur;
    logic [3:0] prev;
    logic [3:0] exp_pix;
  } vec_t;

  vec_t vecs[9];

  motion_detector dut_a (
    .clk             (clk),
    .reset           (reset),
    .frame_end       (frame_end),
    .pix_valid       (pix_valid),
    .cur_gray        (cur_gray),
    .prev_gray       (prev_gray),
    .diff_valid      (a_diff_valid),
    .diff_pixel      (a_diff_pixel),
    .motion_detected (a_md),
    .motion_count    (a_count)
  );

  motion_detector #(
    .PIX_THRESH   (3),
    .COUNT_THRESH (10),
    .HOLD_FRAMES  (3),
    .CNT_W        (4)
  ) dut_b (
    .clk             (clk),
    .reset           (reset),
    .frame_end       (frame_end),
    .pix_valid       (pix_valid),
    .cur_gray        (cur_gray),
    .prev_gray       (prev_gray),
    .diff_valid      (b_diff_valid),
    .diff_pixel      (b_diff_pixel),
    .motion_detected (b_md),
    .motion_count    (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change on the falling edge, so every drive owns one whole clock cycle.
  task automatic drive(input logic [3:0] c, input logic [3:0] p, input logic v, input logic fe);
    @(negedge clk);
    cur_gray  = c;
    prev_gray = p;
    pix_valid = v;
    frame_end = fe;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  // n changed pixels (|9-5| = 4); optionally frame_end on the last one.
  task automatic hits(input int n, input bit fe_last);
    for (int i = 0; i < n; i++) drive(4'd9, 4'd5, 1'b1, fe_last && (i == n - 1));
  endtask

  // n hits, then a lone frame_end in cycle F, returning in cycle F+3.
  task automatic close_frame(input int n);
    hits(n, 1'b0);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic check_a(input string tag, input int cnt, input bit md);
    check({tag, " a_count"}, 32'(a_count), 32'(cnt));
    check({tag, " a_md"}, 32'(a_md), 32'(md));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{cur: 4'd9,  prev: 4'd5,  exp_pix: 4'hF};
    vecs[1] = '{cur: 4'd5,  prev: 4'd7,  exp_pix: 4'h0};
    vecs[2] = '{cur: 4'd0,  prev: 4'd15, exp_pix: 4'hF};
    vecs[3] = '{cur: 4'd15, prev: 4'd0,  exp_pix: 4'hF};
    vecs[4] = '{cur: 4'd3,  prev: 4'd0,  exp_pix: 4'hF};
    vecs[5] = '{cur: 4'd0,  prev: 4'd2,  exp_pix: 4'h0};
    vecs[6] = '{cur: 4'd7,  prev: 4'd7,  exp_pix: 4'h0};
    vecs[7] = '{cur: 4'd1,  prev: 4'd4,  exp_pix: 4'hF};
    vecs[8] = '{cur: 4'd6,  prev: 4'd4,  exp_pix: 4'h0};

    reset = 1'b1; frame_end = 1'b0; pix_valid = 1'b0; cur_gray = '0; prev_gray = '0;
    idle(2);
    check("reset a_diff_valid", 32'(a_diff_valid), 0);
    check("reset a_diff_pixel", 32'(a_diff_pixel), 0);
    check_a("reset", 0, 0);
    check("reset b_count", 32'(b_count), 0);
    reset = 1'b0;
    idle(2);

    // Per-pixel table: pixel in N, nothing yet in N+1, result in N+2.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].cur, vecs[i].prev, 1'b1, 1'b0);
      drive(4'd0, 4'd0, 1'b0, 1'b0);
      check($sformatf("vec%0d diff_valid@N+1", i), 32'(a_diff_valid), 0);
      drive(4'd0, 4'd0, 1'b0, 1'b0);
      check($sformatf("vec%0d diff_valid", i), 32'(a_diff_valid), 1);
      check($sformatf("vec%0d diff_pixel", i), 32'(a_diff_pixel), 32'(vecs[i].exp_pix));
    end

    // Discard the table hits and restart in WARMUP.
    idle(2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    idle(1);

    // Frame 1 (WARMUP): counted but not evaluated; dut_b saturates at 15.
    hits(250, 1'b0);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    idle(2);
    check("f1 a_count@F+2", 32'(a_count), 0);
    idle(1);
    check_a("f1", 250, 0);
    check("f1 b_count sat", 32'(b_count), 15);
    check("f1 b_md", 32'(b_md), 0);

    // Frame 2 (RUN): qualifies on both.
    close_frame(250);
    check_a("f2", 250, 1);
    check("f2 b_count", 32'(b_count), 15);
    check("f2 b_md", 32'(b_md), 1);

    // Quiet closes: dut_b hold of 3 drops at the third.
    close_frame(0);
    check_a("q1", 0, 1);
    check("q1 b_md", 32'(b_md), 1);
    close_frame(0);
    check("q2 b_md", 32'(b_md), 1);
    close_frame(0);
    check("q3 b_md", 32'(b_md), 0);
    check("q3 a_md", 32'(a_md), 1);

    // Back-to-back closes: 5 hits closed, then an immediately following empty frame.
    hits(5, 1'b1);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    idle(3);
    check_a("b2b", 0, 1);

    // dut_a hold is now 25: still high after 24 more quiet closes, low after 25.
    for (int i = 0; i < 24; i++) close_frame(0);
    check("hold24 a_md", 32'(a_md), 1);
    close_frame(0);
    check("hold25 a_md", 32'(a_md), 0);

    // COUNT_THRESH boundary.
    close_frame(199);
    check_a("c199", 199, 0);
    hits(200, 1'b1);
    drive(4'd9, 4'd5, 1'b1, 1'b0);
    idle(2);
    check_a("c200", 200, 1);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    idle(3);
    check_a("carry", 1, 1);

    // Asynchronous reset mid-frame while motion is high.
    hits(50, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("areset a_diff_valid", 32'(a_diff_valid), 0);
    check("areset a_diff_pixel", 32'(a_diff_pixel), 0);
    check_a("areset", 0, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    close_frame(300);
    check_a("post-reset", 300, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
